rx_limites_faixa: RTL and testbench

- Receives range limits over the serial line and parses them into the 12-bit BCD limit pair (`lowerL`, `upperL`) consumed by the range-measurement datapath's comparator.
- Sits directly upstream of that datapath, on the host-to-board direction.
- Frame format is the same 7E1 used by the outgoing measurement stream.
- The command is six ASCII decimal digits followed by `#` (lower limit first, then upper limit, most significant digit first).

---
 rtl/rx_limites_faixa.sv | 189 ++++++++++++++++++
 tb/tb_rx_limites_faixa.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rx_limites_faixa.sv
// rtl/rx_limites_faixa.sv - serial 7E1 receiver and parser for BCD range limits
// Accepts "LLLUUU#" commands and commits lowerL/upperL only when lower <= upper.
module rx_limites_faixa #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [11:0] LOWER_RESET  = 12'h010,
  parameter logic [11:0] UPPER_RESET  = 12'h020
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [11:0] lowerL,
  output logic [11:0] upperL,
  output logic        novos_limites,
  output logic        erro,
  output logic        ocupado,
  output logic [3:0]  db_estado
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_BITS} rx_state_t;
  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    RECEBE      = 4'd1,
    ESPERA_HASH = 4'd2,
    ATUALIZA    = 4'd3,
    DESCARTA    = 4'd4
  } p_state_t;

  rx_state_t r_state, r_next;
  p_state_t  p_state, p_next;

  logic          rx_meta, rx_s, rx_prev;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    sh;
  logic          byte_ok, perr, ferr;
  logic [6:0]    rx_byte;
  logic          half_done, bit_done;

  assign half_done = (cnt == HALF_LAST);
  assign bit_done  = (cnt == BIT_LAST);

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rx_prev && !rx_s) r_next = R_START;
      R_START: if (half_done) r_next = rx_s ? R_IDLE : R_BITS;
      R_BITS:  if (bit_done && bit_idx == 4'd8) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Synchronizer clears low so a line held low across reset is not seen as a new start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
      rx_prev <= 1'b0;
      r_state <= R_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      byte_ok <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      rx_byte <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      r_state <= r_next;
      byte_ok <= 1'b0;
      case (r_state)
        R_START: cnt <= half_done ? '0 : cnt + 1'b1;
        R_BITS: begin
          if (bit_done) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 4'd8) begin
              byte_ok <= 1'b1;
              rx_byte <= sh[6:0];
              perr    <= ^sh;
              ferr    <= !rx_s;
            end else begin
              sh <= {rx_s, sh[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  logic        good, is_digit, is_hash;
  logic [23:0] stage;
  logic [2:0]  k, k_next;
  logic        shift_en, load_en, erro_next, novos_next;

  assign good     = byte_ok && !perr && !ferr;
  assign is_digit = good && (rx_byte >= 7'h30) && (rx_byte <= 7'h39);
  assign is_hash  = good && (rx_byte == 7'h23);

  always_comb begin
    p_next     = p_state;
    k_next     = k;
    shift_en   = 1'b0;
    load_en    = 1'b0;
    erro_next  = 1'b0;
    novos_next = 1'b0;
    case (p_state)
      INICIAL: if (byte_ok) begin
        if (is_digit) begin
          shift_en = 1'b1;
          k_next   = 3'd1;
          p_next   = RECEBE;
        end else if (!is_hash) begin
          erro_next = 1'b1;
          p_next    = DESCARTA;
        end
      end
      RECEBE: if (byte_ok) begin
        if (is_digit) begin
          shift_en = 1'b1;
          k_next   = k + 1'b1;
          if (k == 3'd5) p_next = ESPERA_HASH;
        end else begin
          erro_next = 1'b1;
          k_next    = 3'd0;
          p_next    = is_hash ? INICIAL : DESCARTA;
        end
      end
      ESPERA_HASH: if (byte_ok) begin
        k_next = 3'd0;
        if (is_hash) p_next = ATUALIZA;
        else begin
          erro_next = 1'b1;
          p_next    = DESCARTA;
        end
      end
      ATUALIZA: begin
        // Plain binary compare is valid on BCD since every nibble is 0..9.
        if (stage[23:12] <= stage[11:0]) begin
          load_en    = 1'b1;
          novos_next = 1'b1;
        end else begin
          erro_next = 1'b1;
        end
        k_next = 3'd0;
        p_next = INICIAL;
      end
      DESCARTA: if (is_hash) p_next = INICIAL;
      default: p_next = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_state       <= INICIAL;
      k             <= '0;
      stage         <= '0;
      lowerL        <= LOWER_RESET;
      upperL        <= UPPER_RESET;
      novos_limites <= 1'b0;
      erro          <= 1'b0;
    end else begin
      p_state       <= p_next;
      k             <= k_next;
      novos_limites <= novos_next;
      erro          <= erro_next;
      if (shift_en) stage <= {stage[19:0], rx_byte[3:0]};
      if (load_en) begin
        lowerL <= stage[23:12];
        upperL <= stage[11:0];
      end
    end
  end

  assign ocupado   = (p_state != INICIAL);
  assign db_estado = p_state;

endmodule

// File: tb/tb_rx_limites_faixa.sv
// tb/tb_rx_limites_faixa.sv - directed-vector bench for rx_limites_faixa
// Drives 7E1 frames at 8 clocks per bit and checks limits, pulses and state.
module tb_rx_limites_faixa;

  localparam int CPB = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [11:0] lowerL, upperL;
  logic        novos_limites, erro, ocupado;
  logic [3:0]  db_estado;

  rx_limites_faixa #(.CLKS_PER_BIT(CPB), .LOWER_RESET(12'h010), .UPPER_RESET(12'h020)) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .lowerL(lowerL), .upperL(upperL),
    .novos_limites(novos_limites), .erro(erro), .ocupado(ocupado),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int novos_cnt = 0, erro_cnt = 0, both_cnt = 0, last_novos = 0;
  always @(negedge clock) begin
    if (novos_limites) begin
      novos_cnt++;
      last_novos = cyc;
    end
    if (erro) erro_cnt++;
    if (novos_limites && erro) both_cnt++;
  end

  int n_checks = 0, n_fail = 0;
  int frame_end = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [6:0] d, input bit bad_par);
    logic [9:0] f;
    f = {1'b1, (^d) ^ bad_par, d, 1'b0};
    @(posedge clock); #1;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clock);
      #1;
    end
    frame_end = cyc;
  endtask

  task automatic send_str(input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      send_byte(c[6:0], 1'b0);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  int n0, e0, lat;

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    idle(5);
    @(negedge clock);
    check("rst_lower", lowerL, 12'h010);
    check("rst_upper", upperL, 12'h020);
    check("rst_erro", erro, 0);
    check("rst_estado", db_estado, 0);
    check("rst_ocupado", ocupado, 0);

    // valid command
    n0 = novos_cnt; e0 = erro_cnt;
    send_str("015030#");
    idle(10);
    @(negedge clock);
    lat = last_novos - frame_end;
    check("ok_novos_cnt", novos_cnt - n0, 1);
    check("ok_latency", (lat >= 0 && lat <= 4), 1);
    check("ok_erro_cnt", erro_cnt - e0, 0);
    check("ok_lower", lowerL, 12'h015);
    check("ok_upper", upperL, 12'h030);
    check("ok_ocupado", ocupado, 0);
    check("ok_estado", db_estado, 0);

    // lower > upper
    n0 = novos_cnt; e0 = erro_cnt;
    idle(10);
    send_str("040030#");
    idle(10);
    check("ord_erro_cnt", erro_cnt - e0, 1);
    check("ord_novos_cnt", novos_cnt - n0, 0);
    check("ord_lower", lowerL, 12'h015);
    check("ord_upper", upperL, 12'h030);

    // non-digit, discard, then valid command
    n0 = novos_cnt; e0 = erro_cnt;
    send_str("01A999999#");
    idle(10);
    check("bad_erro_cnt", erro_cnt - e0, 1);
    check("bad_novos_cnt", novos_cnt - n0, 0);
    check("bad_estado", db_estado, 0);
    send_str("005400#");
    idle(10);
    check("rec_novos_cnt", novos_cnt - n0, 1);
    check("rec_lower", lowerL, 12'h005);
    check("rec_upper", upperL, 12'h400);

    // parity error mid-command
    n0 = novos_cnt; e0 = erro_cnt;
    send_str("01");
    send_byte(7'h35, 1'b1);
    idle(4);
    check("par_estado", db_estado, 4);
    send_str("5030#");
    idle(10);
    check("par_erro_cnt", erro_cnt - e0, 1);
    check("par_novos_cnt", novos_cnt - n0, 0);
    check("par_lower", lowerL, 12'h005);
    check("par_upper", upperL, 12'h400);
    check("par_estado_end", db_estado, 0);

    // short glitch is a false start
    e0 = erro_cnt;
    rx = 1'b0;
    repeat (3) @(posedge clock);
    #1 rx = 1'b1;
    idle(30);
    check("glitch_erro_cnt", erro_cnt - e0, 0);
    check("glitch_estado", db_estado, 0);

    // reset during the third digit
    send_str("12");
    @(posedge clock); #1;
    rx = 1'b0;
    repeat (3 * CPB) @(posedge clock);
    #1 rx = 1'b1;
    @(negedge clock);
    check("mid_ocupado", ocupado, 1);
    check("mid_estado", db_estado, 1);
    reset = 1'b1;
    #1;
    check("ar_lower", lowerL, 12'h010);
    check("ar_upper", upperL, 12'h020);
    check("ar_ocupado", ocupado, 0);
    check("ar_estado", db_estado, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    idle(20);
    n0 = novos_cnt; e0 = erro_cnt;
    send_str("100200#");
    idle(10);
    check("post_novos_cnt", novos_cnt - n0, 1);
    check("post_erro_cnt", erro_cnt - e0, 0);
    check("post_lower", lowerL, 12'h100);
    check("post_upper", upperL, 12'h200);
    check("never_both", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
